dm_sba_axil: RTL

Protocol bridge directly downstream of the debug module's system bus access master port. It accepts the single-outstanding req/gnt/r_valid transaction interface and issues the equivalent AXI4-Lite read or write, one at a time. Once the AXI response arrives, it returns a single-cycle completion pulse with read data and an error flag. It sits between the debug module and the SoC interconnect and adds no buffering beyond one transaction.

---
 rtl/dm_sba_axil.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dm_sba_axil.sv
// Bridge from the debug module's req/gnt/r_valid SBA master port to AXI4-Lite.
// Carries exactly one transaction at a time and returns a one-cycle completion pulse.
module dm_sba_axil #(
    parameter int BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [BusWidth-1:0]   add_i,
    input  logic                  we_i,
    input  logic [BusWidth-1:0]   wdata_i,
    input  logic [BusWidth/8-1:0] be_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [BusWidth-1:0]   r_rdata_o,
    output logic                  r_err_o,
    output logic                  aw_valid_o,
    input  logic                  aw_ready_i,
    output logic [BusWidth-1:0]   aw_addr_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    output logic [BusWidth-1:0]   w_data_o,
    output logic [BusWidth/8-1:0] w_strb_o,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [1:0]            b_resp_i,
    output logic                  ar_valid_o,
    input  logic                  ar_ready_i,
    output logic [BusWidth-1:0]   ar_addr_o,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [BusWidth-1:0]   r_data_i,
    input  logic [1:0]            r_resp_i
);

    typedef enum logic [2:0] {Idle, Write, WaitB, Read, WaitR, Resp} state_e;

    state_e                state_q, state_d;
    logic [BusWidth-1:0]   addr_q, data_q, rdata_q;
    logic [BusWidth/8-1:0] strb_q;
    logic                  aw_done_q, w_done_q, err_q;
    logic                  aw_hs, w_hs;

    assign aw_hs = aw_valid_o & aw_ready_i;
    assign w_hs  = w_valid_o & w_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= Idle;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                Idle: begin
                    if (req_i) begin
                        addr_q    <= add_i;
                        data_q    <= wdata_i;
                        strb_q    <= be_i;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                Write: begin
                    if (aw_hs) aw_done_q <= 1'b1;
                    if (w_hs)  w_done_q  <= 1'b1;
                end
                WaitB: begin
                    if (b_valid_i) begin
                        err_q   <= b_resp_i[1];
                        rdata_q <= '0;
                    end
                end
                WaitR: begin
                    if (r_valid_i) begin
                        err_q   <= r_resp_i[1];
                        rdata_q <= r_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write completes when both channels are done, including handshakes in this very cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            Idle:  if (req_i) state_d = we_i ? Write : Read;
            Write: if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WaitB;
            WaitB: if (b_valid_i) state_d = Resp;
            Read:  if (ar_ready_i) state_d = WaitR;
            WaitR: if (r_valid_i) state_d = Resp;
            Resp:  state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    always_comb begin
        gnt_o      = 1'b0;
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        b_ready_o  = 1'b0;
        ar_valid_o = 1'b0;
        r_ready_o  = 1'b0;
        r_valid_o  = 1'b0;
        r_rdata_o  = '0;
        r_err_o    = 1'b0;
        case (state_q)
            Idle:  gnt_o = req_i;
            Write: begin
                aw_valid_o = ~aw_done_q;
                w_valid_o  = ~w_done_q;
            end
            WaitB: b_ready_o  = 1'b1;
            Read:  ar_valid_o = 1'b1;
            WaitR: r_ready_o  = 1'b1;
            Resp: begin
                r_valid_o = 1'b1;
                r_rdata_o = rdata_q;
                r_err_o   = err_q;
            end
            default: ;
        endcase
    end

    assign aw_addr_o = addr_q;
    assign ar_addr_o = addr_q;
    assign w_data_o  = data_q;
    assign w_strb_o  = strb_q;

endmodule
